// File: rtl/noc_outport_alloc_if.sv
// Handshake and data bundle between the input FIFOs, one output-port allocator
// and the downstream link.
interface noc_outport_alloc_if #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_IN-1:0]            req;
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic                         dcts;
    logic [NUM_IN-1:0]            grant;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_rts;
    logic                         busy;
    logic [NUM_IN-1:0]            owner;
    logic                         err_len;

    modport master (
        output req, in_valid, in_data, dcts,
        input  grant, out_data, out_rts, busy, owner, err_len
    );

    modport slave (
        input  req, in_valid, in_data, dcts,
        output grant, out_data, out_rts, busy, owner, err_len
    );
endinterface

// File: rtl/noc_outport_alloc.sv
// Per-output-port slice of the NoC router: round-robin wormhole arbiter,
// NUM_IN-way crossbar mux and registered output stage.
module noc_outport_alloc #(
    parameter int          NUM_IN      = 5,
    parameter int          DATA_WIDTH  = 32,
    parameter int          LEN_WIDTH   = 12,
    parameter logic [2:0]  FLIT_HEADER = 3'b001,
    parameter logic [2:0]  FLIT_TAIL   = 3'b100
) (
    input logic               clk,
    input logic               rst,
    noc_outport_alloc_if.slave bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_IN - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [LEN_WIDTH-1:0]  remaining_r, remaining_nxt_s;
    logic [IDX_W-1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0]      owner_idx_r, owner_idx_nxt_s;
    logic [NUM_IN-1:0]     eligible_s;
    logic [NUM_IN-1:0]     grant_s;
    logic                  pick_vld_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic [DATA_WIDTH-1:0] sel_flit_s;
    logic [LEN_WIDTH-1:0]  eff_len_s;
    logic                  xfer_s;
    logic                  err_nxt_s;
    logic                  busy_nxt_s;

    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_rts_r;
    logic                  busy_r;
    logic [NUM_IN-1:0]     owner_r;
    logic                  err_len_r;

    function automatic logic [2:0] flit_id(input logic [DATA_WIDTH-1:0] flit);
        return flit[DATA_WIDTH-1 -: 3];
    endfunction

    function automatic logic [LEN_WIDTH-1:0] flit_len(input logic [DATA_WIDTH-1:0] flit);
        return flit[DATA_WIDTH-4 -: LEN_WIDTH];
    endfunction

    function automatic logic [NUM_IN-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_IN-1:0] v;
        v = {NUM_IN{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Inputs presenting a header flit routed to this output
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible_s[i] = bus.req[i] & bus.in_valid[i] &
                            (flit_id(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]) == FLIT_HEADER);
        end
    end

    // Round-robin search starting just after the last packet's input
    always_comb begin
        int cand;
        pick_vld_s = 1'b0;
        pick_idx_s = {IDX_W{1'b0}};
        cand       = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = int'(rr_ptr_r) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end else begin
                cand = cand;
            end
            if (!pick_vld_s && eligible_s[cand]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = IDX_W'(cand);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Crossbar select: owner while locked, arbitration winner otherwise
    always_comb begin
        if (state_r == LOCKED) begin
            sel_idx_s = owner_idx_r;
        end else begin
            sel_idx_s = pick_idx_s;
        end
        sel_flit_s = bus.in_data[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
        eff_len_s  = (flit_len(sel_flit_s) == LEN_ZERO) ? LEN_ONE : flit_len(sel_flit_s);
    end

    // Next-state, grant and packet bookkeeping
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        owner_idx_nxt_s = owner_idx_r;
        grant_s         = {NUM_IN{1'b0}};
        err_nxt_s       = 1'b0;
        if (rst) begin
            grant_s = {NUM_IN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.dcts && pick_vld_s) begin
                        grant_s[pick_idx_s] = 1'b1;
                        if (eff_len_s == LEN_ONE) begin
                            rr_ptr_nxt_s = pick_idx_s;
                        end else begin
                            state_nxt_s     = LOCKED;
                            owner_idx_nxt_s = pick_idx_s;
                            remaining_nxt_s = eff_len_s - LEN_ONE;
                        end
                    end else begin
                        grant_s = {NUM_IN{1'b0}};
                    end
                end
                LOCKED: begin
                    if (bus.dcts && bus.in_valid[owner_idx_r]) begin
                        grant_s[owner_idx_r] = 1'b1;
                        remaining_nxt_s      = remaining_r - LEN_ONE;
                        if (remaining_r == LEN_ONE) begin
                            state_nxt_s  = IDLE;
                            rr_ptr_nxt_s = owner_idx_r;
                        end else if (flit_id(sel_flit_s) == FLIT_TAIL) begin
                            // Tail arrived before the header's flit count ran out
                            state_nxt_s  = IDLE;
                            rr_ptr_nxt_s = owner_idx_r;
                            err_nxt_s    = 1'b1;
                        end else begin
                            state_nxt_s = LOCKED;
                        end
                    end else begin
                        grant_s = {NUM_IN{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Busy covers the lock and the output cycle of the packet's last flit
    always_comb begin
        xfer_s     = |grant_s;
        busy_nxt_s = (state_nxt_s == LOCKED) | ((state_r == LOCKED) & xfer_s);
    end

    // State and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= LEN_ZERO;
            rr_ptr_r    <= LAST_IDX;
            owner_idx_r <= {IDX_W{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_rts_r   <= 1'b0;
            busy_r      <= 1'b0;
            owner_r     <= {NUM_IN{1'b0}};
            err_len_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            owner_idx_r <= owner_idx_nxt_s;
            out_data_r  <= xfer_s ? sel_flit_s : out_data_r;
            out_rts_r   <= xfer_s;
            busy_r      <= busy_nxt_s;
            owner_r     <= busy_nxt_s ? onehot(owner_idx_nxt_s) : {NUM_IN{1'b0}};
            err_len_r   <= err_nxt_s;
        end
    end

    assign bus.grant    = grant_s;
    assign bus.out_data = out_data_r;
    assign bus.out_rts  = out_rts_r;
    assign bus.busy     = busy_r;
    assign bus.owner    = owner_r;
    assign bus.err_len  = err_len_r;
endmodule

// File: doc/noc_outport_alloc.md
Name: noc_outport_alloc

Overview:
- Parametrised per-output-port slice of the NoC router: round-robin wormhole arbiter, NUM_IN-way crossbar mux and registered output stage in one block.
- Supersedes the fixed 5-input arbiter/xbar/output_buffer triple.
- Channel count, data width and length-field width are generalised.
- Adds packet locking by flit count, early-tail detection and a busy/owner status.
- One instance per output port; instantiated by the next-generation parametrised router.

Parameters:
- NUM_IN, 5, number of input ports competing for this output (>=2).
- DATA_WIDTH, 32, flit width in bits.
- LEN_WIDTH, 12, width of the header length field (total flits in packet, header included).
- FLIT_HEADER, 3'b001, flit-id code for a header flit.
- FLIT_TAIL, 3'b100, flit-id code for a tail flit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req  in  NUM_IN  input i's routing logic selects this output for its head flit
- in_valid  in  NUM_IN  input i's FIFO is non-empty (flit present at head)
- in_data  in  NUM_IN*DATA_WIDTH  FIFO head flits; input i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- dcts  in  1  downstream clear-to-send
- grant  out  NUM_IN  one-hot read-enable to input FIFO i; combinational
- out_data  out  DATA_WIDTH  registered flit to next router/NI
- out_rts  out  1  registered request-to-send; one-cycle pulse per flit
- busy  out  1  registered; a packet is locked to this output
- owner  out  NUM_IN  registered one-hot current owner; 0 when idle
- err_len  out  1  registered one-cycle pulse on early tail

Behaviour:
- Flit fields: id = flit[DATA_WIDTH-1 -: 3]; len = flit[DATA_WIDTH-4 -: LEN_WIDTH], read from the header only.
- Reset values: out_data=0, out_rts=0, busy=0, owner=0, err_len=0, state=IDLE, remaining=0, rr_ptr=NUM_IN-1 (input 0 has first priority).
- A transfer happens in any cycle where grant!=0. grant is at most one-hot and is never asserted while dcts=0.
- Latency: the flit granted in cycle t appears on out_data with out_rts=1 in cycle t+1. With no transfer, out_rts=0 and out_data holds its last value.
- State IDLE:
  - Eligible inputs: req[i] & in_valid[i] & id==FLIT_HEADER.
  - If dcts=1 and any input is eligible, grant the first eligible input searching rr_ptr+1, rr_ptr+2, ... modulo NUM_IN.
  - Effective length L = len, or 1 if len==0.
  - If L==1: stay IDLE and set rr_ptr=i.
  - Else: go to LOCKED with owner=i, busy=1, remaining=L-1.
- State LOCKED:
  - grant[owner] = in_valid[owner] & dcts. All other inputs are ignored, so no interleaving.
  - Each transfer decrements remaining.
  - On a transfer with remaining==1: return to IDLE, owner=0, busy=0, rr_ptr=owner index.
  - On a transfer of a FLIT_TAIL flit with remaining>1: return to IDLE as above and pulse err_len for one cycle.
  - A header flit arriving while LOCKED is forwarded as payload; no special action.
- Back-to-back packets: a new header may be granted in the cycle immediately after the LOCKED->IDLE transition (IDLE evaluates combinationally).
- dcts low: no grant, no state change, remaining preserved.
- Reset mid-packet: all state and outputs return to reset values on the next clock edge; the partial packet is abandoned, with no err_len pulse.
- Arithmetic: remaining is LEN_WIDTH bits and never wraps, because it is only decremented while >=1.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> grant=0, out_rts=0, busy=0, owner=0, err_len=0.
- Single packet: input 2, header len=3 followed by 2 flits, dcts=1 throughout -> grant=5'b00100 in cycles 0-2; out_rts=1 in cycles 1-3 with matching data; busy=1 in cycles 1-3, then 0; owner=5'b00100 while busy.
- Contention: inputs 0 and 3 each present a len=2 header in the same cycle after reset -> input 0's two flits go first, then input 3's (grants in cycles 0,1,2,3); no interleave. Next contention between 0 and 3 -> input 0 again (rr_ptr=3 after input 3's packet).
- Backpressure: len=4 packet; dcts=0 during cycles 2-3 -> no grant or out_rts in those cycles; the remaining 2 flits transfer in cycles 4-5; total of 4 out_rts pulses.
- Early tail: header len=5, tail as flit 3 -> IDLE after flit 3, err_len=1 for one cycle (cycle 3), busy=0; the next header is accepted immediately.
- Zero/one length and reset mid-packet:
  - len=0 header -> single-flit transfer, stays IDLE.
  - rst asserted after flit 2 of a len=6 packet -> busy=0 next cycle; input 0 has priority afterwards.
